timer_multi: RTL and testbench

Memory-mapped, parametrised 64-bit machine timer with `CHANNELS` independent compare registers, a programmable tick prescaler and one interrupt line per channel. It generalises the fixed single-compare timer at `timer_base_address` to several harts or event channels. It sits on the core's data-memory bus behind the address decoder, and its interrupt outputs feed the CSR/interrupt logic.

---
 rtl/timer_multi.sv | 133 +++++++++++++
 tb/tb_timer_multi.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_multi.sv
// 64-bit memory-mapped machine timer with CHANNELS compare registers, a tick prescaler and per-channel level irq.
// Every request gets timer_ready one cycle later, with no wait states and no stall; timer_irq is registered from the compare.
module timer_multi #(
  parameter logic [31:0] BASE_ADDR      = 32'h0020_0000,
  parameter int          CHANNELS       = 2,
  parameter int          PRESCALE_WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                timer_valid,
  input  logic [31:0]         timer_addr,
  input  logic [31:0]         timer_wdata,
  input  logic [3:0]          timer_wstrb,
  output logic [31:0]         timer_rdata,
  output logic                timer_ready,
  output logic [CHANNELS-1:0] timer_irq
);

  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [29:0] WIN_WORDS = 30'(4 + 2 * CHANNELS);

  typedef struct packed {
    logic        in_win;
    logic        wr;
    logic [29:0] word;
  } req_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_dat,
                                              input logic [31:0] new_dat,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_dat;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_dat[8*b +: 8];
    end
    return res;
  endfunction

  logic [63:0]               mtime;
  logic [63:0]               mtime_nxt;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] pcnt;
  logic [63:0]               mtimecmp [CHANNELS];
  logic                      tick;

  req_t                      req;
  logic [29:0]               word_addr;
  logic                      wr_mtime_lo;
  logic                      wr_mtime_hi;
  logic                      wr_pre;
  logic [CHANNELS-1:0]       wr_cmp_lo;
  logic [CHANNELS-1:0]       wr_cmp_hi;
  logic [31:0]               pre_merged;
  logic [31:0]               rd_mux;
  logic                      unused_bits;

  // Word-granular decode; the low two address bits are ignored.
  assign word_addr  = timer_addr[31:2];
  assign req.word   = word_addr - BASE_WORD;
  assign req.in_win = (word_addr >= BASE_WORD) && (req.word < WIN_WORDS);
  assign req.wr     = timer_valid && req.in_win && (timer_wstrb != 4'b0000);

  assign wr_mtime_lo = req.wr && (req.word == 30'd0);
  assign wr_mtime_hi = req.wr && (req.word == 30'd1);
  assign wr_pre      = req.wr && (req.word == 30'd2);

  always_comb begin
    wr_cmp_lo = '0;
    wr_cmp_hi = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_cmp_lo[i] = req.wr && (req.word == 30'(4 + 2 * i));
      wr_cmp_hi[i] = req.wr && (req.word == 30'(5 + 2 * i));
    end
  end

  assign tick       = (pcnt == prescale);
  assign pre_merged = merge_bytes(32'(prescale), timer_wdata, timer_wstrb);

  // A software write to either half wins over the tick and is stored verbatim.
  always_comb begin
    mtime_nxt = tick ? mtime + 64'd1 : mtime;
    if (wr_mtime_lo || wr_mtime_hi) begin
      mtime_nxt = mtime;
      if (wr_mtime_lo) mtime_nxt[31:0]  = merge_bytes(mtime[31:0], timer_wdata, timer_wstrb);
      if (wr_mtime_hi) mtime_nxt[63:32] = merge_bytes(mtime[63:32], timer_wdata, timer_wstrb);
    end
  end

  always_comb begin
    rd_mux = '0;
    if (req.in_win) begin
      if (req.word == 30'd0) rd_mux = mtime[31:0];
      if (req.word == 30'd1) rd_mux = mtime[63:32];
      if (req.word == 30'd2) rd_mux = 32'(prescale);
      for (int i = 0; i < CHANNELS; i++) begin
        if (req.word == 30'(4 + 2 * i)) rd_mux = mtimecmp[i][31:0];
        if (req.word == 30'(5 + 2 * i)) rd_mux = mtimecmp[i][63:32];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime       <= '0;
      pcnt        <= '0;
      prescale    <= '0;
      for (int i = 0; i < CHANNELS; i++) mtimecmp[i] <= '1;
      timer_irq   <= '0;
      timer_ready <= 1'b0;
      timer_rdata <= '0;
    end else begin
      mtime <= mtime_nxt;
      if (wr_pre) begin
        prescale <= pre_merged[PRESCALE_WIDTH-1:0];
        pcnt     <= '0;
      end else if (tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRESCALE_WIDTH'(1);
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_cmp_lo[i]) mtimecmp[i][31:0]  <= merge_bytes(mtimecmp[i][31:0], timer_wdata, timer_wstrb);
        if (wr_cmp_hi[i]) mtimecmp[i][63:32] <= merge_bytes(mtimecmp[i][63:32], timer_wdata, timer_wstrb);
        timer_irq[i] <= (mtime >= mtimecmp[i]);
      end
      timer_ready <= timer_valid;
      timer_rdata <= timer_valid ? rd_mux : 32'd0;
    end
  end

  assign unused_bits = ^{timer_addr[1:0], pre_merged};

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: register-map table plus hand-timed prescaler, irq, wrap and reset sequences.
module tb_timer_multi;
  localparam logic [31:0] BASE = 32'h0020_0000;
  localparam int          CH   = 2;
  localparam int          NV   = 20;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            timer_valid = 1'b0;
  logic [31:0]     timer_addr  = '0;
  logic [31:0]     timer_wdata = '0;
  logic [3:0]      timer_wstrb = '0;
  logic [31:0]     timer_rdata;
  logic            timer_ready;
  logic [CH-1:0]   timer_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] off;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [NV];

  timer_multi #(.BASE_ADDR(BASE), .CHANNELS(CH), .PRESCALE_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .timer_valid (timer_valid),
    .timer_addr  (timer_addr),
    .timer_wdata (timer_wdata),
    .timer_wstrb (timer_wstrb),
    .timer_rdata (timer_rdata),
    .timer_ready (timer_ready),
    .timer_irq   (timer_irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; the request is taken at the next edge.
  task automatic bus(input logic [31:0] off, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd);
    timer_valid = 1'b1;
    timer_addr  = BASE + off;
    timer_wdata = wd;
    timer_wstrb = ws;
    @(posedge clock);
    #1;
    timer_valid = 1'b0;
    timer_wstrb = 4'b0000;
    check("ready", 64'(timer_ready), 64'd1);
    rd = timer_rdata;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] r;
    bus(off, wd, ws, r);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] r;
    bus(off, 32'd0, 4'b0000, r);
    check(name, 64'(r), 64'(exp));
  endtask

  task automatic set_vec(input int i, input logic [31:0] off, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] exp);
    tbl[i].off = off;
    tbl[i].wd  = wd;
    tbl[i].ws  = ws;
    tbl[i].exp = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;

    set_vec(0,  32'h00, 32'h0, 4'h0, 32'h0);          // first edge after reset: mtime still 0
    set_vec(1,  32'h04, 32'h0, 4'h0, 32'h0);
    set_vec(2,  32'h08, 32'h0, 4'h0, 32'h0);
    set_vec(3,  32'h0C, 32'h0, 4'h0, 32'h0);
    set_vec(4,  32'h10, 32'h0, 4'h0, 32'hFFFF_FFFF);
    set_vec(5,  32'h14, 32'h0, 4'h0, 32'hFFFF_FFFF);
    set_vec(6,  32'h18, 32'h0, 4'h0, 32'hFFFF_FFFF);
    set_vec(7,  32'h1C, 32'h0, 4'h0, 32'hFFFF_FFFF);
    set_vec(8,  32'h20, 32'h0, 4'h0, 32'h0);
    set_vec(9,  32'h20, 32'h0, 4'hF, 32'h0);
    set_vec(10, 32'h0C, 32'h1234_5678, 4'hF, 32'h0);
    set_vec(11, 32'h0C, 32'h0, 4'h0, 32'h0);
    set_vec(12, 32'h10, 32'h0, 4'h0, 32'hFFFF_FFFF);
    set_vec(13, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0);
    set_vec(14, 32'h08, 32'hABCD_1205, 4'hF, 32'h0);
    set_vec(15, 32'h08, 32'h0, 4'h0, 32'h0000_0005);
    set_vec(16, 32'h18, 32'h0000_00AA, 4'b0001, 32'h0);
    set_vec(17, 32'h18, 32'h0, 4'h0, 32'hFFFF_FFAA);
    set_vec(18, 32'h1C, 32'h0, 4'h0, 32'hFFFF_FFFF);
    set_vec(19, 32'h08, 32'h0, 4'hF, 32'h0);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst ready", 64'(timer_ready), 64'd0);
    check("rst rdata", 64'(timer_rdata), 64'd0);
    check("rst irq",   64'(timer_irq),   64'd0);
    reset = 1'b0;

    // Register map, window edges, byte strobes, prescale truncation
    for (int i = 0; i < NV; i++) begin
      bus(tbl[i].off, tbl[i].wd, tbl[i].ws, r);
      if (tbl[i].ws == 4'b0000) check($sformatf("vec%0d rdata", i), 64'(r), 64'(tbl[i].exp));
      check($sformatf("vec%0d irq", i), 64'(timer_irq), 64'd0);
    end

    // Compare 1 = 20; mtime cleared at edge c; irq[1] rises after edge c+21
    wr(32'h18, 32'd20, 4'hF);
    wr(32'h1C, 32'd0, 4'hF);
    wr(32'h04, 32'd0, 4'hF);
    wr(32'h00, 32'd0, 4'hF);
    repeat (20) @(posedge clock);
    #1;
    check("irq1 before", 64'(timer_irq), 64'd0);
    @(posedge clock);
    #1;
    check("irq1 rise", 64'(timer_irq), 64'b10);
    rd_chk("mtime at irq", 32'h00, 32'd21);

    // Prescale 3: write at p, mtime cleared at p+1, read at p+k sees floor((k-1)/4)
    wr(32'h08, 32'd3, 4'hF);
    wr(32'h00, 32'd0, 4'hF);
    for (int k = 2; k <= 41; k++) rd_chk($sformatf("psc k%0d", k), 32'h00, 32'((k - 1) / 4));
    // Rewrite prescale at q restarts phase: read at q+k sees 10 + floor((k-1)/4)
    wr(32'h08, 32'd3, 4'hF);
    for (int k = 1; k <= 12; k++) rd_chk($sformatf("restart k%0d", k), 32'h00, 32'(10 + (k - 1) / 4));

    // Byte write landing on a tick cycle suppresses the increment
    wr(32'h08, 32'd3, 4'hF);
    wr(32'h00, 32'h1234_5678, 4'hF);
    wr(32'h04, 32'd0, 4'hF);
    rd_chk("psc readback", 32'h08, 32'd3);
    wr(32'h00, 32'h0000_AB00, 4'b0010);
    rd_chk("byte lo",  32'h00, 32'h1234_AB78);
    rd_chk("byte hi",  32'h04, 32'h0);
    rd_chk("byte s7",  32'h00, 32'h1234_AB78);
    rd_chk("byte s8",  32'h00, 32'h1234_AB78);
    rd_chk("byte s9",  32'h00, 32'h1234_AB79);

    // Wrap from all-ones with compare 0 = 5
    wr(32'h08, 32'd0, 4'hF);
    wr(32'h10, 32'd5, 4'hF);
    wr(32'h14, 32'd0, 4'hF);
    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF);
    @(posedge clock);
    #1;
    check("irq at max", 64'(timer_irq), 64'b11);
    rd_chk("wrap lo", 32'h00, 32'd0);
    check("irq after wrap", 64'(timer_irq), 64'b00);
    rd_chk("wrap hi", 32'h04, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("irq0 pre", 64'(timer_irq[0]), 64'd0);
    @(posedge clock);
    #1;
    check("irq0 rise", 64'(timer_irq[0]), 64'd1);

    // Reset with a request in flight
    wr(32'h08, 32'd2, 4'hF);
    timer_valid = 1'b1;
    timer_addr  = BASE + 32'h08;
    timer_wdata = 32'd0;
    timer_wstrb = 4'h0;
    @(posedge clock);
    #1;
    check("inflight ready", 64'(timer_ready), 64'd1);
    timer_wdata = 32'd7;
    timer_wstrb = 4'hF;
    #2;
    reset = 1'b1;
    #1;
    check("async ready", 64'(timer_ready), 64'd0);
    @(posedge clock);
    #1;
    timer_valid = 1'b0;
    timer_wstrb = 4'h0;
    check("reset ready", 64'(timer_ready), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("release ready", 64'(timer_ready), 64'd0);
    check("release irq",   64'(timer_irq),   64'd0);
    rd_chk("post mtime lo", 32'h00, 32'd0);
    rd_chk("post mtime hi", 32'h04, 32'd0);
    rd_chk("post prescale", 32'h08, 32'd0);
    rd_chk("post cmp0 lo",  32'h10, 32'hFFFF_FFFF);
    rd_chk("post cmp1 lo",  32'h18, 32'hFFFF_FFFF);
    check("post irq", 64'(timer_irq), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
